// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : ID-stage decode fields in, pipeline hold/bubble/kill controls out.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5
);
    localparam int NUM_REGS = 2**REG_AW;

    logic                id_valid;
    logic [REG_AW-1:0]   id_rs;
    logic [REG_AW-1:0]   id_rt;
    logic                id_rs_used;
    logic                id_rt_used;
    logic [REG_AW-1:0]   id_rd;
    logic                id_we;
    logic [1:0]          id_kind;
    logic                id_branch;
    logic                ex_redirect;

    logic                stall;
    logic                bubble;
    logic                flush;
    logic                issue;
    logic [NUM_REGS-1:0] pending;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_we, id_kind, id_branch, ex_redirect,
        input  stall, bubble, flush, issue, pending
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_we, id_kind, id_branch, ex_redirect,
        output stall, bubble, flush, issue, pending
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Countdown scoreboard resolving RAW/WAW/mul-structural hazards in
//            ID and stretching front-end flushes on control redirects.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW    = 5,
    parameter int LAT_W     = 3,
    parameter int ALU_LAT   = 1,
    parameter int LOAD_LAT  = 2,
    parameter int MUL_LAT   = 4,
    parameter int FLUSH_CYC = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_scoreboard_if.slave sb
);
    localparam int NUM_REGS = 2**REG_AW;
    localparam int FL_W     = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [1:0]       c_kind_load  = 2'd1;
    localparam logic [1:0]       c_kind_mul   = 2'd2;
    localparam logic [LAT_W-1:0] c_alu_lat    = LAT_W'(ALU_LAT);
    localparam logic [LAT_W-1:0] c_load_lat   = LAT_W'(LOAD_LAT);
    localparam logic [LAT_W-1:0] c_mul_lat    = LAT_W'(MUL_LAT);
    localparam logic [LAT_W-1:0] c_mul_reload = LAT_W'(MUL_LAT - 1);
    localparam logic [LAT_W-1:0] c_lat_one    = LAT_W'(1);
    localparam logic [FL_W-1:0]  c_fl_reload  = FL_W'(FLUSH_CYC - 1);
    localparam logic [FL_W-1:0]  c_fl_one     = FL_W'(1);

    logic [LAT_W-1:0] w_cnt [NUM_REGS];
    logic [LAT_W-1:0] r_mul_busy;
    logic [FL_W-1:0]  r_fl_cnt;

    logic [LAT_W-1:0] w_lat;
    logic [LAT_W-1:0] w_thr;
    logic             w_raw_rs;
    logic             w_raw_rt;
    logic             w_waw;
    logic             w_struct;
    logic             w_flush;
    logic             w_stall;
    logic             w_issue;
    logic             w_load;

    // Result latency of the instruction in ID; kind 3 decodes as ALU.
    always_comb begin
        w_lat = c_alu_lat;
        case (sb.id_kind)
            c_kind_load: w_lat = c_load_lat;
            c_kind_mul:  w_lat = c_mul_lat;
            default:     w_lat = c_alu_lat;
        endcase
    end

    // Branches compare in ID, so they cannot use the EX bypass a count of 1 implies.
    assign w_thr    = sb.id_branch ? '0 : c_lat_one;

    assign w_raw_rs = sb.id_rs_used && (sb.id_rs != '0) && (w_cnt[sb.id_rs] > w_thr);
    assign w_raw_rt = sb.id_rt_used && (sb.id_rt != '0) && (w_cnt[sb.id_rt] > w_thr);
    assign w_waw    = sb.id_we && (sb.id_rd != '0) && (w_cnt[sb.id_rd] > w_lat);
    assign w_struct = (sb.id_kind == c_kind_mul) && (r_mul_busy != '0);

    assign w_flush  = sb.ex_redirect || (r_fl_cnt != '0);
    assign w_stall  = sb.id_valid && !w_flush && (w_raw_rs || w_raw_rt || w_waw || w_struct);
    assign w_issue  = sb.id_valid && !w_stall && !w_flush;
    assign w_load   = w_issue && sb.id_we && (sb.id_rd != '0);

    assign sb.flush  = w_flush;
    assign sb.stall  = w_stall;
    assign sb.bubble = w_stall || w_flush;
    assign sb.issue  = w_issue;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        if (r == 0) begin : g_zero
            assign w_cnt[r] = '0;
        end else begin : g_live
            logic [LAT_W-1:0] r_cnt;

            // A fresh issue to this register wins over its own decrement.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_load && (sb.id_rd == REG_AW'(r))) begin
                    r_cnt <= w_lat;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_lat_one;
                end
            end

            assign w_cnt[r] = r_cnt;
        end

        assign sb.pending[r] = (w_cnt[r] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_busy <= '0;
        end else if (w_issue && (sb.id_kind == c_kind_mul)) begin
            r_mul_busy <= c_mul_reload;
        end else if (r_mul_busy != '0) begin
            r_mul_busy <= r_mul_busy - c_lat_one;
        end
    end

    // A redirect arriving mid-flush restarts the flush window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fl_cnt <= '0;
        end else if (sb.ex_redirect) begin
            r_fl_cnt <= c_fl_reload;
        end else if (r_fl_cnt != '0) begin
            r_fl_cnt <= r_fl_cnt - c_fl_one;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed bench for hazard_scoreboard with a timestamp-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    localparam int REG_AW    = 5;
    localparam int NUM_REGS  = 32;
    localparam int ALU_LAT   = 1;
    localparam int LOAD_LAT  = 2;
    localparam int MUL_LAT   = 4;
    localparam int FLUSH_CYC = 3;

    localparam logic [1:0] K_ALU  = 2'd0;
    localparam logic [1:0] K_LOAD = 2'd1;
    localparam logic [1:0] K_MUL  = 2'd2;
    localparam logic [1:0] K_RSV  = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(REG_AW)) sb_if ();

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .LAT_W    (3),
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT),
        .MUL_LAT  (MUL_LAT),
        .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (sb_if)
    );

    int checks = 0;
    int errors = 0;

    // Model: absolute cycle at which each result / the multiplier / the front end frees up.
    int now = 0;
    int ready [NUM_REGS];
    int mul_free = 0;
    int flush_until = 0;

    typedef struct packed {
        logic                stall;
        logic                bubble;
        logic                flush;
        logic                issue;
        logic [NUM_REGS-1:0] pending;
    } out_t;

    function automatic int lat_of(logic [1:0] k);
        case (k)
            K_LOAD:  return LOAD_LAT;
            K_MUL:   return MUL_LAT;
            default: return ALU_LAT;
        endcase
    endfunction

    function automatic int remain(int r);
        if (r == 0) return 0;
        return (ready[r] > now) ? ready[r] - now : 0;
    endfunction

    function automatic out_t model_eval();
        out_t o;
        bit   haz;
        int   thr;
        o.flush = sb_if.ex_redirect || (now < flush_until);
        thr = sb_if.id_branch ? 0 : 1;
        haz = 1'b0;
        if (sb_if.id_rs_used && sb_if.id_rs != 0 && remain(int'(sb_if.id_rs)) > thr) haz = 1'b1;
        if (sb_if.id_rt_used && sb_if.id_rt != 0 && remain(int'(sb_if.id_rt)) > thr) haz = 1'b1;
        if (sb_if.id_we && sb_if.id_rd != 0 && remain(int'(sb_if.id_rd)) > lat_of(sb_if.id_kind)) haz = 1'b1;
        if (sb_if.id_kind == K_MUL && now < mul_free) haz = 1'b1;
        o.stall  = sb_if.id_valid && !o.flush && haz;
        o.bubble = o.stall || o.flush;
        o.issue  = sb_if.id_valid && !o.stall && !o.flush;
        for (int r = 0; r < NUM_REGS; r++) o.pending[r] = (remain(r) != 0);
        return o;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, now, got, exp);
        end
    endtask

    always @(posedge clk) begin
        out_t m;
        m = model_eval();
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
            mul_free    = 0;
            flush_until = 0;
        end else begin
            if (m.issue && sb_if.id_we && sb_if.id_rd != 0)
                ready[sb_if.id_rd] = now + 1 + lat_of(sb_if.id_kind);
            if (m.issue && sb_if.id_kind == K_MUL) mul_free = now + MUL_LAT;
            if (sb_if.ex_redirect) flush_until = now + FLUSH_CYC;
        end
        now++;
    end

    always @(negedge clk) begin
        out_t m;
        m = model_eval();
        chk("cyc_stall",   64'(sb_if.stall),   64'(m.stall));
        chk("cyc_bubble",  64'(sb_if.bubble),  64'(m.bubble));
        chk("cyc_flush",   64'(sb_if.flush),   64'(m.flush));
        chk("cyc_issue",   64'(sb_if.issue),   64'(m.issue));
        chk("cyc_pending", 64'(sb_if.pending), 64'(m.pending));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.id_valid    = 1'b0;
        sb_if.id_rs       = '0;
        sb_if.id_rt       = '0;
        sb_if.id_rs_used  = 1'b0;
        sb_if.id_rt_used  = 1'b0;
        sb_if.id_rd       = '0;
        sb_if.id_we       = 1'b0;
        sb_if.id_kind     = K_ALU;
        sb_if.id_branch   = 1'b0;
        sb_if.ex_redirect = 1'b0;
    endtask

    task automatic drive(logic [1:0] kind, logic [4:0] rd, logic we,
                         logic [4:0] rs, logic rsu, logic [4:0] rt, logic rtu, logic br);
        sb_if.id_valid   = 1'b1;
        sb_if.id_kind    = kind;
        sb_if.id_rd      = rd;
        sb_if.id_we      = we;
        sb_if.id_rs      = rs;
        sb_if.id_rs_used = rsu;
        sb_if.id_rt      = rt;
        sb_if.id_rt_used = rtu;
        sb_if.id_branch  = br;
    endtask

    task automatic drain();
        idle();
        repeat (6) tick();
    endtask

    // Counts stall cycles until the current ID instruction issues; -1 on timeout.
    task automatic run_until_issue(output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (sb_if.issue) return;
            if (sb_if.stall) n++;
            tick();
        end
        n = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nfl;
        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_pending", 64'(sb_if.pending), 64'd0);
        chk("reset_stall",   64'(sb_if.stall),   64'd0);
        chk("reset_flush",   64'(sb_if.flush),   64'd0);
        tick();

        // Load r5 then add r6 <- r5 + r1.
        drive(K_LOAD, 5'd5, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ld_issue", 64'(sb_if.issue), 64'd1);
        tick();
        drive(K_ALU, 5'd6, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0);
        @(negedge clk);
        chk("lu_stall",  64'(sb_if.stall),      64'd1);
        chk("lu_bubble", 64'(sb_if.bubble),     64'd1);
        chk("lu_issue0", 64'(sb_if.issue),      64'd0);
        chk("lu_pend5a", 64'(sb_if.pending[5]), 64'd1);
        tick();
        @(negedge clk);
        chk("lu_stall2", 64'(sb_if.stall),      64'd0);
        chk("lu_issue1", 64'(sb_if.issue),      64'd1);
        chk("lu_pend5b", 64'(sb_if.pending[5]), 64'd1);
        tick();
        idle();
        @(negedge clk);
        chk("lu_pend5c", 64'(sb_if.pending[5]), 64'd0);
        chk("lu_pend6",  64'(sb_if.pending[6]), 64'd1);
        drain();

        // Load r5 then beq r5, r0: two stalls.
        drive(K_LOAD, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        run_until_issue(n);
        tick();
        drive(K_ALU, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b1, 1'b1);
        run_until_issue(n);
        chk("ld_br_stalls", 64'(n), 64'(2));
        tick();
        drain();

        // ALU r5 then beq r5, r0: one stall.
        drive(K_ALU, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        run_until_issue(n);
        tick();
        drive(K_ALU, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b1, 1'b1);
        run_until_issue(n);
        chk("alu_br_stalls", 64'(n), 64'(1));
        tick();
        drain();

        // ALU r5 then ALU reading r5: no stall.
        drive(K_ALU, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        run_until_issue(n);
        tick();
        drive(K_ALU, 5'd7, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
        run_until_issue(n);
        chk("alu_alu_stalls", 64'(n), 64'(0));
        tick();
        drain();

        // mul r3, mul r4, add r7 <- r3.
        drive(K_MUL, 5'd3, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        run_until_issue(n);
        tick();
        drive(K_MUL, 5'd4, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        run_until_issue(n);
        chk("mul_mul_stalls", 64'(n), 64'(3));
        tick();
        drive(K_ALU, 5'd7, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        run_until_issue(n);
        chk("mul_add_stalls", 64'(n), 64'(0));
        tick();
        drain();

        // WAW: mul r8 then ALU write r8.
        drive(K_MUL, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        run_until_issue(n);
        tick();
        drive(K_ALU, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        run_until_issue(n);
        chk("waw_stalls", 64'(n), 64'(3));
        tick();
        drive(K_MUL, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        run_until_issue(n);
        chk("r0_mul_stalls", 64'(n), 64'(0));
        tick();
        drive(K_ALU, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        run_until_issue(n);
        chk("r0_alu_stalls", 64'(n), 64'(0));
        tick();
        idle();
        @(negedge clk);
        chk("r0_pending", 64'(sb_if.pending[0]), 64'd0);
        drain();

        // Reserved kind decodes with ALU latency: WAW against a load stalls once.
        drive(K_LOAD, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        run_until_issue(n);
        tick();
        drive(K_RSV, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        run_until_issue(n);
        chk("kind3_waw_stalls", 64'(n), 64'(1));
        tick();
        drain();

        // Redirect while stalled on a load-use.
        drive(K_LOAD, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        run_until_issue(n);
        tick();
        drive(K_ALU, 5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        sb_if.ex_redirect = 1'b1;
        @(negedge clk);
        chk("rd_stall",  64'(sb_if.stall),      64'd0);
        chk("rd_flush",  64'(sb_if.flush),      64'd1);
        chk("rd_bubble", 64'(sb_if.bubble),     64'd1);
        chk("rd_issue",  64'(sb_if.issue),      64'd0);
        nfl = 1;
        tick();
        sb_if.ex_redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!sb_if.flush) break;
            nfl++;
            chk("rd_pend6_flush", 64'(sb_if.pending[6]), 64'd0);
            tick();
        end
        chk("flush_len",        64'(nfl),         64'(3));
        chk("post_flush_issue", 64'(sb_if.issue), 64'd1);
        tick();
        drain();

        // Reset pulse during a mul structural stall.
        drive(K_MUL, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        run_until_issue(n);
        tick();
        drive(K_MUL, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstmul_stall", 64'(sb_if.stall), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmul_pending", 64'(sb_if.pending), 64'd0);
        chk("rstmul_stall2",  64'(sb_if.stall),   64'd0);
        chk("rstmul_issue",   64'(sb_if.issue),   64'd1);
        tick();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
